// File: rtl/unidade_controle_jogada_pkg.sv
// Shared state encoding for the play control unit and its display decoder.
// The enum values are the DB_ESTADO codes, so the state register drives the debug port directly.
package unidade_controle_jogada_pkg;

    localparam logic [3:0] DB_INICIAL     = 4'h0;
    localparam logic [3:0] DB_PREPARACAO  = 4'h1;
    localparam logic [3:0] DB_ESPERA      = 4'h2;
    localparam logic [3:0] DB_REGISTRA    = 4'h4;
    localparam logic [3:0] DB_COMPARACAO  = 4'h5;
    localparam logic [3:0] DB_PROXIMO     = 4'h6;
    localparam logic [3:0] DB_FIM_ACERTO  = 4'hA;
    localparam logic [3:0] DB_FIM_TIMEOUT = 4'hD;
    localparam logic [3:0] DB_FIM_ERRO    = 4'hE;

    typedef enum logic [3:0] {
        ST_INICIAL     = DB_INICIAL,
        ST_PREPARACAO  = DB_PREPARACAO,
        ST_ESPERA      = DB_ESPERA,
        ST_REGISTRA    = DB_REGISTRA,
        ST_COMPARACAO  = DB_COMPARACAO,
        ST_PROXIMO     = DB_PROXIMO,
        ST_FIM_ACERTO  = DB_FIM_ACERTO,
        ST_FIM_TIMEOUT = DB_FIM_TIMEOUT,
        ST_FIM_ERRO    = DB_FIM_ERRO
    } estado_t;

    function automatic logic is_fim(input estado_t st);
        return (st == ST_FIM_ACERTO) || (st == ST_FIM_ERRO) || (st == ST_FIM_TIMEOUT);
    endfunction

endpackage

// File: rtl/unidade_controle_jogada_edge_detector.sv
// Two-flop synchronizer plus rising-edge detector; pulse is valid the cycle after din is first seen on sync2.
// No backpressure: one single-cycle pulse per rising edge, lost if the consumer is not listening.
module edge_detector (
    input  logic CLK,
    input  logic RST_N,
    input  logic din,
    output logic pulse
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic prev_q,  prev_d;

    always_comb begin
        sync1_d = din;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
        end
    end

    assign pulse = sync2_q & ~prev_q;

endmodule

// File: rtl/unidade_controle_jogada.sv
// Moore control FSM for one sequence-memory round: clear counter, wait/timeout, register, compare, advance.
// Press-to-REGISTRA latency 2 edges after first sample; presses outside ESPERA are dropped, never queued.
module unidade_controle_jogada
    import unidade_controle_jogada_pkg::*;
#(
    parameter int TIMEOUT_CICLOS = 5000,
    parameter int TW             = 13
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       INICIAR,
    input  logic       JOGADA,
    input  logic       IGUAL,
    input  logic       FIM,
    output logic       ZERA_C,
    output logic       CONTA_C,
    output logic       REGISTRA,
    output logic       PRONTO,
    output logic       ACERTOU,
    output logic       ERROU,
    output logic       TIMEOUT,
    output logic [3:0] DB_ESTADO
);

    localparam logic [TW-1:0] TO_TERMINAL = TW'(TIMEOUT_CICLOS - 1);

    estado_t       state_q, state_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic          jogada_pulse;

    edge_detector u_edge_detector (
        .CLK   (CLK),
        .RST_N (RST_N),
        .din   (JOGADA),
        .pulse (jogada_pulse)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= ST_INICIAL;
            to_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            to_cnt_q <= to_cnt_d;
        end
    end

    // Counter only runs while waiting; leaving ESPERA at terminal count keeps it from wrapping.
    always_comb begin
        to_cnt_d = '0;
        if (state_q == ST_ESPERA) begin
            to_cnt_d = to_cnt_q + TW'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_INICIAL:    if (INICIAR) state_d = ST_PREPARACAO;
            ST_PREPARACAO: state_d = ST_ESPERA;
            ST_ESPERA: begin
                // A press on the expiry cycle still wins over the timeout.
                if (jogada_pulse) begin
                    state_d = ST_REGISTRA;
                end else if (to_cnt_q == TO_TERMINAL) begin
                    state_d = ST_FIM_TIMEOUT;
                end
            end
            ST_REGISTRA:   state_d = ST_COMPARACAO;
            ST_COMPARACAO: begin
                if (!IGUAL) begin
                    state_d = ST_FIM_ERRO;
                end else if (FIM) begin
                    state_d = ST_FIM_ACERTO;
                end else begin
                    state_d = ST_PROXIMO;
                end
            end
            ST_PROXIMO:    state_d = ST_ESPERA;
            ST_FIM_ACERTO,
            ST_FIM_ERRO,
            ST_FIM_TIMEOUT: if (INICIAR) state_d = ST_PREPARACAO;
            default:       state_d = ST_INICIAL;
        endcase
    end

    always_comb begin
        ZERA_C   = 1'b0;
        CONTA_C  = 1'b0;
        REGISTRA = 1'b0;
        ACERTOU  = 1'b0;
        ERROU    = 1'b0;
        TIMEOUT  = 1'b0;
        PRONTO   = is_fim(state_q);
        unique case (state_q)
            ST_PREPARACAO:  ZERA_C   = 1'b1;
            ST_REGISTRA:    REGISTRA = 1'b1;
            ST_PROXIMO:     CONTA_C  = 1'b1;
            ST_FIM_ACERTO:  ACERTOU  = 1'b1;
            ST_FIM_ERRO:    ERROU    = 1'b1;
            ST_FIM_TIMEOUT: TIMEOUT  = 1'b1;
            default: ;
        endcase
    end

    assign DB_ESTADO = state_q;

endmodule

// File: tb/tb_unidade_controle_jogada.sv
// Bench for unidade_controle_jogada with TIMEOUT_CICLOS = 8 and a behavioural 163-style counter.
// Rounds are described as per-play (delay, hold, match) lists and judged by a round-level outcome model.
module tb_unidade_controle_jogada;
    import unidade_controle_jogada_pkg::*;

    localparam int T = 8;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       INICIAR = 1'b0;
    logic       JOGADA = 1'b0;
    logic       IGUAL = 1'b1;
    logic       FIM;
    logic       ZERA_C, CONTA_C, REGISTRA, PRONTO, ACERTOU, ERROU, TIMEOUT;
    logic [3:0] DB_ESTADO;

    unidade_controle_jogada #(.TIMEOUT_CICLOS(T), .TW(4)) dut (
        .CLK(CLK), .RST_N(RST_N), .INICIAR(INICIAR), .JOGADA(JOGADA),
        .IGUAL(IGUAL), .FIM(FIM), .ZERA_C(ZERA_C), .CONTA_C(CONTA_C),
        .REGISTRA(REGISTRA), .PRONTO(PRONTO), .ACERTOU(ACERTOU),
        .ERROU(ERROU), .TIMEOUT(TIMEOUT), .DB_ESTADO(DB_ESTADO)
    );

    always #5 CLK = ~CLK;

    // Address counter: synchronous clear, count enable, RCO at 15.
    logic [3:0] cq = 4'd0;
    assign FIM = (cq == 4'hF);
    always @(posedge CLK) begin
        if (ZERA_C) cq <= 4'd0;
        else if (CONTA_C) cq <= cq + 4'd1;
    end

    int n_reg = 0;
    int n_conta = 0;
    always @(negedge CLK) begin
        if (REGISTRA) n_reg <= n_reg + 1;
        if (CONTA_C) n_conta <= n_conta + 1;
    end

    int errors = 0;
    int checks = 0;

    int dly[16];
    int hold[16];
    bit mat[16];

    typedef struct {
        int         err_at;
        int         to_at;
        int         to_gap;
        logic [3:0] exp_code;
        int         exp_q;
        int         exp_regs;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic bound_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: wait bound expired, state %0h", name, DB_ESTADO);
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_state(input logic [3:0] st, input string name);
        int b = 0;
        while (DB_ESTADO != st && b < 40) begin tick; b++; end
        if (b >= 40) bound_fail(name);
    endtask

    // Starts from INICIAL or an end state; returns just after the edge that enters ESPERA.
    task automatic start_round;
        INICIAR = 1'b1;
        tick;
        INICIAR = 1'b0;
        chk("prep_state", DB_ESTADO, DB_PREPARACAO);
        chk("prep_zera", ZERA_C, 1);
        chk("prep_flags", {PRONTO, ACERTOU, ERROU, TIMEOUT}, 0);
        tick;
        chk("espera_state", DB_ESTADO, DB_ESPERA);
        chk("espera_zera", ZERA_C, 0);
        chk("cnt_cleared", cq, 0);
    endtask

    task automatic play_round;
        for (int k = 0; k < 16; k++) begin
            int b;
            IGUAL = mat[k];
            repeat (dly[k]) tick;
            JOGADA = 1'b1;
            repeat (hold[k]) tick;
            JOGADA = 1'b0;
            b = 0;
            while (DB_ESTADO == DB_ESPERA && b < 40) begin tick; b++; end
            while (DB_ESTADO != DB_ESPERA && !PRONTO && b < 80) begin tick; b++; end
            if (b >= 80) bound_fail("play_progress");
            if (PRONTO) break;
        end
    endtask

    // A press raised d cycles into ESPERA pulses d+2 cycles in; it counts only if that is
    // within the T waiting cycles (last one T-1), otherwise the round times out first.
    task automatic model(output logic [3:0] code, output int q, output int regs);
        code = DB_FIM_ACERTO; q = 15; regs = 16;
        for (int k = 0; k < 16; k++) begin
            if (dly[k] + 2 > T - 1) begin
                code = DB_FIM_TIMEOUT; q = k; regs = k;
                break;
            end
            if (!mat[k]) begin
                code = DB_FIM_ERRO; q = k; regs = k + 1;
                break;
            end
        end
    endtask

    task automatic check_round(input string tag, input logic [3:0] code, input int q,
                               input int regs, input int r0, input int c0);
        chk({tag, "_code"}, DB_ESTADO, code);
        chk({tag, "_q"}, cq, q);
        chk({tag, "_regs"}, n_reg - r0, regs);
        chk({tag, "_conta"}, n_conta - c0, q);
        chk({tag, "_pronto"}, PRONTO, 1);
        chk({tag, "_flags"}, {ACERTOU, ERROU, TIMEOUT},
            {code == DB_FIM_ACERTO, code == DB_FIM_ERRO, code == DB_FIM_TIMEOUT});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t       vecs[7];
        logic [3:0] m_code;
        int         m_q, m_regs, r0, c0, i;

        vecs[0] = '{-1, -1, 0, DB_FIM_ACERTO, 15, 16};
        vecs[1] = '{ 2, -1, 0, DB_FIM_ERRO,    2,  3};
        vecs[2] = '{ 0, -1, 0, DB_FIM_ERRO,    0,  1};
        vecs[3] = '{-1,  0, 6, DB_FIM_TIMEOUT, 0,  0};
        vecs[4] = '{-1,  5, 5, DB_FIM_ACERTO, 15, 16};
        vecs[5] = '{15, -1, 0, DB_FIM_ERRO,   15, 16};
        vecs[6] = '{-1, 15, 9, DB_FIM_TIMEOUT,15, 15};

        // Reset state
        #3;
        chk("rst_state", DB_ESTADO, DB_INICIAL);
        chk("rst_outs", {ZERA_C, CONTA_C, REGISTRA, PRONTO, ACERTOU, ERROU, TIMEOUT}, 0);
        #9 RST_N = 1'b1;
        tick;
        chk("idle_after_rst", DB_ESTADO, DB_INICIAL);
        repeat (3) tick;
        chk("idle_no_iniciar", DB_ESTADO, DB_INICIAL);

        // Press latency, then reset asserted in COMPARACAO
        start_round;
        IGUAL = 1'b1;
        JOGADA = 1'b1;
        tick;
        tick;
        chk("lat_still_espera", DB_ESTADO, DB_ESPERA);
        tick;
        chk("lat_registra", DB_ESTADO, DB_REGISTRA);
        chk("lat_registra_out", REGISTRA, 1);
        JOGADA = 1'b0;
        tick;
        chk("lat_comparacao", DB_ESTADO, DB_COMPARACAO);
        #1 RST_N = 1'b0;
        #1;
        chk("midrst_state", DB_ESTADO, DB_INICIAL);
        chk("midrst_outs", {ZERA_C, CONTA_C, REGISTRA, PRONTO, ACERTOU, ERROU, TIMEOUT}, 0);
        #4 RST_N = 1'b1;
        tick;
        chk("midrst_hold", DB_ESTADO, DB_INICIAL);
        repeat (4) tick;
        chk("midrst_no_restart", DB_ESTADO, DB_INICIAL);

        // Table-driven rounds; vector 1 ends in FIM_ERRO so vector 2 exercises the restart path
        for (int v = 0; v < 7; v++) begin
            for (int k = 0; k < 16; k++) begin
                dly[k] = k % 3;
                hold[k] = 1 + (k % 3);
                mat[k] = 1'b1;
            end
            if (vecs[v].err_at >= 0) mat[vecs[v].err_at] = 1'b0;
            if (vecs[v].to_at >= 0) dly[vecs[v].to_at] = vecs[v].to_gap;
            start_round;
            r0 = n_reg; c0 = n_conta;
            play_round;
            check_round($sformatf("vec%0d", v), vecs[v].exp_code, vecs[v].exp_q,
                        vecs[v].exp_regs, r0, c0);
            repeat (3) tick;
        end

        // Timeout lands exactly T edges after entering ESPERA
        start_round;
        i = 0;
        while (DB_ESTADO == DB_ESPERA && i < 20) begin tick; i++; end
        chk("to_edges", i, T);
        chk("to_state", DB_ESTADO, DB_FIM_TIMEOUT);
        chk("to_flag", {PRONTO, TIMEOUT}, 2'b11);
        repeat (2) tick;

        // Button held for 50 cycles registers once, then the round times out
        start_round;
        r0 = n_reg;
        IGUAL = 1'b1;
        JOGADA = 1'b1;
        repeat (50) tick;
        JOGADA = 1'b0;
        chk("held_regs", n_reg - r0, 1);
        chk("held_state", DB_ESTADO, DB_FIM_TIMEOUT);
        chk("held_q", cq, 1);
        repeat (4) tick;

        // Second press whose pulse lands in PROXIMO is dropped; held level gives no new edge
        start_round;
        r0 = n_reg;
        JOGADA = 1'b1;
        tick;
        JOGADA = 1'b0;
        wait_state(DB_REGISTRA, "early_wait_reg");
        JOGADA = 1'b1;
        wait_state(DB_PROXIMO, "early_wait_prox");
        repeat (20) tick;
        JOGADA = 1'b0;
        chk("early_regs", n_reg - r0, 1);
        chk("early_state", DB_ESTADO, DB_FIM_TIMEOUT);
        chk("early_q", cq, 1);
        repeat (4) tick;

        // Randomized rounds against the outcome model
        for (int r = 0; r < 30; r++) begin
            for (int k = 0; k < 16; k++) begin
                dly[k] = ($urandom_range(0, 19) == 0) ? int'($urandom_range(6, 9))
                                                      : int'($urandom_range(0, 5));
                hold[k] = int'($urandom_range(1, 3));
                mat[k] = ($urandom_range(0, 24) != 0);
            end
            model(m_code, m_q, m_regs);
            start_round;
            r0 = n_reg; c0 = n_conta;
            play_round;
            check_round($sformatf("rnd%0d", r), m_code, m_q, m_regs, r0, c0);
            repeat (3) tick;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
